bram_arbiter: RTL

- Two-master arbiter directly upstream of the block RAM model.
- Merges the instruction-fetch port (imem_*) and the load/store port (dmem_*) onto the single bram_* request port.
- Keeps at most one BRAM access outstanding and routes bram_ready/bram_rdata back to the master that owns the access.
- Drives bram_instr so the memory can tell fetches from data accesses.

---
 rtl/bram_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bram_arbiter.sv
// Merges fetch (imem) and load/store (dmem) onto one BRAM port, one access in flight; request-to-ready 2 cycles from idle.
// No backpressure: one pending slot per master, a valid while that master is busy is dropped.
module bram_arbiter #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        bram_valid,
  output logic        bram_instr,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wdata,
  output logic [3:0]  bram_wstrb,
  input  logic [31:0] bram_rdata,
  input  logic        bram_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  state_t      state, state_nxt;
  owner_t      owner, owner_nxt;
  logic        issue;
  logic        last_d;

  logic        pend_i;
  logic [31:0] pend_i_addr;
  logic        pend_d;
  logic [31:0] pend_d_addr;
  logic [31:0] pend_d_wdata;
  logic [3:0]  pend_d_wstrb;

  logic        take_i, take_d;
  logic        req_i, req_d;
  logic        grant_i, grant_d;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_wstrb;

  // Reset gates the ready pulses so an abandoned access never completes.
  assign imem_ready = !reset && bram_ready && (state == WAIT) && (owner == OWN_I);
  assign dmem_ready = !reset && bram_ready && (state == WAIT) && (owner == OWN_D);
  assign imem_rdata = bram_rdata;
  assign dmem_rdata = bram_rdata;

  // A master may re-request in its own completion cycle; otherwise a busy master's valid is ignored.
  assign take_i = imem_valid && !pend_i && !((owner == OWN_I) && !imem_ready);
  assign take_d = dmem_valid && !pend_d && !((owner == OWN_D) && !dmem_ready);

  // Incoming requests compete directly so an idle arbiter issues in the very next cycle.
  assign req_i   = pend_i || take_i;
  assign req_d   = pend_d || take_d;
  assign grant_d = req_d && (!req_i || !RR_ENABLE || !last_d);
  assign grant_i = req_i && !grant_d;

  assign sel_addr  = grant_d ? (pend_d ? pend_d_addr : dmem_addr)
                             : (pend_i ? pend_i_addr : imem_addr);
  assign sel_wdata = grant_d ? (pend_d ? pend_d_wdata : dmem_wdata) : 32'h0;
  assign sel_wstrb = grant_d ? (pend_d ? pend_d_wstrb : dmem_wstrb) : 4'h0;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (req_i || req_d) begin
          issue     = 1'b1;
          state_nxt = ISSUE;
          owner_nxt = grant_d ? OWN_D : OWN_I;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (bram_ready) begin
          state_nxt = IDLE;
          owner_nxt = OWN_NONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        owner_nxt = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= OWN_NONE;
      last_d       <= 1'b0;
      pend_i       <= 1'b0;
      pend_i_addr  <= 32'h0;
      pend_d       <= 1'b0;
      pend_d_addr  <= 32'h0;
      pend_d_wdata <= 32'h0;
      pend_d_wstrb <= 4'h0;
      bram_valid   <= 1'b0;
      bram_instr   <= 1'b0;
      bram_addr    <= 32'h0;
      bram_wdata   <= 32'h0;
      bram_wstrb   <= 4'h0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      bram_valid <= issue;
      if (issue) begin
        bram_instr <= grant_i;
        bram_addr  <= sel_addr;
        bram_wdata <= sel_wdata;
        bram_wstrb <= sel_wstrb;
        last_d     <= grant_d;
      end

      // An incoming request that wins immediately bypasses its slot.
      if (take_i && !(issue && grant_i)) begin
        pend_i      <= 1'b1;
        pend_i_addr <= imem_addr;
      end else if (issue && grant_i) begin
        pend_i <= 1'b0;
      end

      if (take_d && !(issue && grant_d)) begin
        pend_d       <= 1'b1;
        pend_d_addr  <= dmem_addr;
        pend_d_wdata <= dmem_wdata;
        pend_d_wstrb <= dmem_wstrb;
      end else if (issue && grant_d) begin
        pend_d <= 1'b0;
      end
    end
  end

endmodule
